// File: rtl/sprite_animator.sv
// Character sprite engine: per-state descriptor table, frame-tick position/animation update,
// and a two-stage pixel pipeline producing sprite-ROM addresses and a keyed hit flag.
module sprite_animator #(
   parameter int unsigned NUM_STATES  = 6,
   parameter int unsigned COORD_W     = 10,
   parameter int unsigned ADDR_W      = 19,
   parameter int unsigned SCALE_SHIFT = 1,
   parameter int unsigned FRAME_HOLD  = 4,
   parameter int unsigned STEP        = 2,
   parameter int unsigned KNOCKBACK   = 5,
   parameter int unsigned X_MIN       = 10,
   parameter int unsigned X_MAX       = 630,
   parameter int unsigned X_INIT      = 50,
   parameter int unsigned Y_INIT      = 300,
   parameter logic [7:0]  TRANSPARENT = 8'h00,
   localparam int unsigned SW = (NUM_STATES > 1) ? $clog2(NUM_STATES) : 1,
   localparam int unsigned DW = 2 * COORD_W + 9
) (
   input  logic               Clk,
   input  logic               Reset_n,
   input  logic               frame_clk,
   input  logic [SW-1:0]      state_in,
   input  logic               facing_left,
   input  logic               move_r,
   input  logic               move_l,
   input  logic               hurt,
   input  logic [COORD_W-1:0] opp_x,
   input  logic               opp_block,
   input  logic               desc_we,
   input  logic [SW-1:0]      desc_idx,
   input  logic [DW-1:0]      desc_data,
   input  logic [COORD_W-1:0] DrawX,
   input  logic [COORD_W-1:0] DrawY,
   output logic [SW-1:0]      rom_sel,
   output logic [ADDR_W-1:0]  rom_addr,
   input  logic [7:0]         rom_data,
   output logic               is_character,
   output logic [7:0]         data_Out,
   output logic [COORD_W-1:0] character_x,
   output logic [7:0]         anim_frame,
   output logic               anim_done
);

   localparam int unsigned PW = COORD_W + 2;
   localparam int unsigned HW = (FRAME_HOLD > 1) ? $clog2(FRAME_HOLD) : 1;

   localparam logic signed [PW-1:0] STEP_S  = PW'(STEP);
   localparam logic signed [PW-1:0] KNOCK_S = PW'(KNOCKBACK);
   localparam logic signed [PW-1:0] XMIN_S  = PW'(X_MIN);
   localparam logic signed [PW-1:0] XMAX_S  = PW'(X_MAX);
   localparam logic signed [PW-1:0] YINIT_S = PW'(Y_INIT);

   typedef struct packed {
      logic [COORD_W-1:0] width;
      logic [COORD_W-1:0] height;
      logic [7:0]         frames;
      logic               loop;
   } desc_t;

   desc_t desc_q [NUM_STATES];
   desc_t cur;

   logic              sync1_q, sync2_q, sync3_q, tick_q, armed_q;
   logic [1:0]        vld_q;

   logic [SW-1:0]      state_q, state_d;
   logic [7:0]         frame_q, frame_d;
   logic [HW-1:0]      hold_q, hold_d;
   logic               done_q, done_d;
   logic               fired_q, fired_d;
   logic [COORD_W-1:0] x_q, x_d;

   logic [SW-1:0]     rom_sel_q;
   logic [ADDR_W-1:0] rom_addr_q, addr;
   logic              hit, hit_q, hit2_q;

   logic [7:0]               nframes, last;
   logic signed [PW-1:0]     px, pw, ph, popp, nx, dx, dy;
   logic [ADDR_W-1:0]        sw_a, sh_a, sx_a, sy_a;

   assign cur = desc_q[state_q];

   // Descriptor table
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         for (int i = 0; i < NUM_STATES; i++) desc_q[i] <= '0;
      end else if (desc_we && (32'(desc_idx) < NUM_STATES)) begin
         desc_q[desc_idx] <= desc_t'(desc_data);
      end
   end

   // Frame strobe synchroniser; armed_q requires a genuine low before the first rising edge
   // after reset, so a strobe that is already high at release does not tick.
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         sync3_q <= 1'b0;
         vld_q   <= 2'b00;
         armed_q <= 1'b0;
         tick_q  <= 1'b0;
      end else begin
         sync1_q <= frame_clk;
         sync2_q <= sync1_q;
         sync3_q <= sync2_q;
         vld_q   <= {vld_q[0], 1'b1};
         armed_q <= armed_q | (vld_q[1] & ~sync2_q);
         tick_q  <= armed_q & sync2_q & ~sync3_q;
      end
   end

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state_q <= '0;
         frame_q <= '0;
         hold_q  <= '0;
         done_q  <= 1'b0;
         fired_q <= 1'b0;
         x_q     <= COORD_W'(X_INIT);
      end else begin
         state_q <= state_d;
         frame_q <= frame_d;
         hold_q  <= hold_d;
         done_q  <= done_d;
         fired_q <= fired_d;
         x_q     <= x_d;
      end
   end

   // Horizontal position candidate, in signed arithmetic wide enough not to wrap
   always_comb begin
      px   = $signed({2'b00, x_q});
      pw   = $signed({2'b00, cur.width});
      popp = $signed({2'b00, opp_x});
      nx   = px;
      if (hurt)                  nx = px - KNOCK_S;
      else if (move_r && !move_l) nx = px + STEP_S;
      else if (move_l && !move_r) nx = px - STEP_S;
      if (opp_block && (nx + pw >= popp)) nx = popp - pw;
      if (nx > XMAX_S - pw) nx = XMAX_S - pw;
      if (nx < XMIN_S)      nx = XMIN_S;
   end

   always_comb begin
      state_d = state_q;
      frame_d = frame_q;
      hold_d  = hold_q;
      done_d  = 1'b0;
      fired_d = fired_q;
      x_d     = x_q;
      nframes = (cur.frames == 8'd0) ? 8'd1 : cur.frames;
      last    = nframes - 8'd1;
      if (tick_q) begin
         x_d = nx[COORD_W-1:0];
         if ((state_in != state_q) && (32'(state_in) < NUM_STATES)) begin
            state_d = state_in;
            frame_d = '0;
            hold_d  = '0;
            fired_d = 1'b0;
         end else if (32'(hold_q) == FRAME_HOLD - 1) begin
            hold_d = '0;
            if (frame_q >= last) begin
               if (cur.loop) begin
                  frame_d = '0;
               end else if (!fired_q) begin
                  done_d  = 1'b1;
                  fired_d = 1'b1;
               end
            end else begin
               frame_d = frame_q + 8'd1;
            end
         end else begin
            hold_d = hold_q + 1'b1;
         end
      end
   end

   // Pixel stage 1: window test and ROM address for the current geometry
   always_comb begin
      ph   = $signed({2'b00, cur.height});
      dx   = $signed({2'b00, DrawX}) - px;
      dy   = $signed({2'b00, DrawY}) - YINIT_S;
      hit  = (dx >= 0) && (dx < pw) && (dy >= 0) && (dy < ph);
      sw_a = ADDR_W'(cur.width >> SCALE_SHIFT);
      sh_a = ADDR_W'(cur.height >> SCALE_SHIFT);
      sx_a = ADDR_W'(dx[COORD_W-1:0] >> SCALE_SHIFT);
      sy_a = ADDR_W'(dy[COORD_W-1:0] >> SCALE_SHIFT);
      if (facing_left) sx_a = sw_a - ADDR_W'(1) - sx_a;
      addr = ADDR_W'(frame_q) * sw_a * sh_a + sy_a * sw_a + sx_a;
   end

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         rom_sel_q  <= '0;
         rom_addr_q <= '0;
         hit_q      <= 1'b0;
         hit2_q     <= 1'b0;
      end else begin
         rom_sel_q  <= state_q;
         rom_addr_q <= hit ? addr : '0;
         hit_q      <= hit;
         hit2_q     <= hit_q;
      end
   end

   // Pixel stage 2: hit flag delayed to line up with the synchronous ROM read
   assign is_character = hit2_q && (rom_data != TRANSPARENT);
   assign data_Out     = is_character ? rom_data : 8'h00;

   assign rom_sel     = rom_sel_q;
   assign rom_addr    = rom_addr_q;
   assign character_x = x_q;
   assign anim_frame  = frame_q;
   assign anim_done   = done_q;

endmodule

// File: tb/tb_sprite_animator.sv
// Randomised scoreboard bench for sprite_animator with a behavioural position/animation model.
module tb_sprite_animator;

   localparam int FH = 4;

   logic        Clk = 1'b0;
   logic        Reset_n = 1'b0;
   logic        frame_clk = 1'b0;
   logic [2:0]  state_in = '0;
   logic        facing_left = 1'b0, move_r = 1'b0, move_l = 1'b0, hurt = 1'b0;
   logic [9:0]  opp_x = '0;
   logic        opp_block = 1'b0;
   logic        desc_we = 1'b0;
   logic [2:0]  desc_idx = '0;
   logic [28:0] desc_data = '0;
   logic [9:0]  DrawX = '0, DrawY = '0;
   logic [2:0]  rom_sel;
   logic [18:0] rom_addr;
   logic [7:0]  rom_data = '0;
   logic        is_character;
   logic [7:0]  data_Out;
   logic [9:0]  character_x;
   logic [7:0]  anim_frame;
   logic        anim_done;

   sprite_animator dut (
      .Clk(Clk), .Reset_n(Reset_n), .frame_clk(frame_clk), .state_in(state_in),
      .facing_left(facing_left), .move_r(move_r), .move_l(move_l), .hurt(hurt),
      .opp_x(opp_x), .opp_block(opp_block), .desc_we(desc_we), .desc_idx(desc_idx),
      .desc_data(desc_data), .DrawX(DrawX), .DrawY(DrawY), .rom_sel(rom_sel),
      .rom_addr(rom_addr), .rom_data(rom_data), .is_character(is_character),
      .data_Out(data_Out), .character_x(character_x), .anim_frame(anim_frame),
      .anim_done(anim_done)
   );

   always #10 Clk = ~Clk;

   int n_tests = 0, n_fail = 0;
   int m_x, m_state, m_k, exp_done, done_cnt = 0;
   int m_w[6], m_h[6], m_f[6], m_l[6];
   int q_sel[$], q_addr[$], q_is[$], q_do[$];
   logic pix_valid = 1'b0, v1 = 1'b0, v2 = 1'b0;

   task automatic check(input string name, input int got, input int exp);
      n_tests++;
      if (got != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, got, exp);
      end
   endtask

   // Sprite ROM contents; some addresses hold the transparent index
   function automatic int romf(input int s, input int a);
      if ((a & 3) == 1) return 0;
      return ((a >> 2) + s * 32 + 33) & 255;
   endfunction

   always @(posedge Clk) rom_data <= 8'(romf(int'(rom_sel), int'(rom_addr)));

   function automatic int m_frame();
      int n, q;
      n = (m_f[m_state] == 0) ? 1 : m_f[m_state];
      q = m_k / FH;
      if (m_l[m_state] != 0) return q % n;
      return (q < n) ? q : n - 1;
   endfunction

   task automatic model_reset();
      m_x = 50; m_state = 0; m_k = 0;
      for (int i = 0; i < 6; i++) begin
         m_w[i] = 0; m_h[i] = 0; m_f[i] = 0; m_l[i] = 0;
      end
   endtask

   task automatic write_desc(input int idx, input int w, input int h, input int f, input int l);
      desc_we = 1'b1;
      desc_idx = idx[2:0];
      desc_data = {w[9:0], h[9:0], f[7:0], l[0]};
      @(posedge Clk); #1;
      desc_we = 1'b0;
      m_w[idx] = w; m_h[idx] = h; m_f[idx] = f; m_l[idx] = l;
   endtask

   task automatic tick(input int sin, input int mr, input int ml, input int hu, input int ob,
                       input int ox);
      int w, nx, n;
      state_in = sin[2:0]; move_r = mr[0]; move_l = ml[0]; hurt = hu[0];
      opp_block = ob[0]; opp_x = ox[9:0];
      frame_clk = 1'b1;
      repeat (6) @(posedge Clk);
      frame_clk = 1'b0;
      repeat (6) @(posedge Clk);
      #1;
      w = m_w[m_state];
      nx = m_x;
      if (hu != 0) nx = nx - 5;
      else if (mr != 0 && ml == 0) nx = nx + 2;
      else if (ml != 0 && mr == 0) nx = nx - 2;
      if (ob != 0 && nx + w >= ox) nx = ox - w;
      if (nx > 630 - w) nx = 630 - w;
      if (nx < 10) nx = 10;
      m_x = nx;
      if (sin != m_state) begin
         m_state = sin; m_k = 0;
      end else begin
         m_k++;
         n = (m_f[m_state] == 0) ? 1 : m_f[m_state];
         if (m_l[m_state] == 0 && m_k == FH * n) exp_done++;
      end
      check("char_x", int'(character_x), m_x);
      check("anim_frame", int'(anim_frame), m_frame());
   endtask

   // Issue one pixel; optionally rewrite the active state's width in the same cycle
   task automatic pixel(input int px, input int py, input int fl, input int new_w);
      int dx, dy, w, h, sw, sh, sx, addr, hit, d;
      DrawX = px[9:0]; DrawY = py[9:0]; facing_left = fl[0]; pix_valid = 1'b1;
      w = m_w[m_state]; h = m_h[m_state];
      dx = px - m_x; dy = py - 300;
      hit = (dx >= 0 && dx < w && dy >= 0 && dy < h) ? 1 : 0;
      sw = w / 2; sh = h / 2;
      sx = (hit != 0) ? dx / 2 : 0;
      if (fl != 0) sx = sw - 1 - sx;
      addr = (hit != 0) ? ((m_frame() * sw * sh + (dy / 2) * sw + sx) & 32'h7ffff) : 0;
      d = romf(m_state, addr);
      q_sel.push_back(m_state); q_addr.push_back(addr);
      q_is.push_back((hit != 0 && d != 0) ? 1 : 0);
      q_do.push_back((hit != 0 && d != 0) ? d : 0);
      if (new_w >= 0) begin
         desc_we = 1'b1;
         desc_idx = m_state[2:0];
         desc_data = {new_w[9:0], m_h[m_state][9:0], m_f[m_state][7:0], m_l[m_state][0]};
      end
      @(posedge Clk); #1;
      if (new_w >= 0) begin
         desc_we = 1'b0;
         m_w[m_state] = new_w;
      end
   endtask

   always @(posedge Clk) begin
      v1 <= pix_valid;
      v2 <= v1;
   end

   always @(negedge Clk) if (anim_done === 1'b1) done_cnt++;

   always @(negedge Clk) begin : monitor
      int es, ea, ei, ed;
      if (v1) begin
         if (q_addr.size() == 0) begin
            n_tests++; n_fail++;
            $display("FAIL sb_addr: address output with empty expectation queue");
         end else begin
            es = q_sel.pop_front(); ea = q_addr.pop_front();
            check("rom_sel", int'(rom_sel), es);
            check("rom_addr", int'(rom_addr), ea);
         end
      end
      if (v2) begin
         if (q_is.size() == 0) begin
            n_tests++; n_fail++;
            $display("FAIL sb_pixel: pixel output with empty expectation queue");
         end else begin
            ei = q_is.pop_front(); ed = q_do.pop_front();
            check("is_character", int'(is_character), ei);
            check("data_Out", int'(data_Out), ed);
         end
      end
   end

   initial begin
      int st, ox, nw;
      model_reset();
      exp_done = 0;
      repeat (3) @(posedge Clk);
      #1;
      check("rst_char_x", int'(character_x), 50);
      check("rst_anim_frame", int'(anim_frame), 0);
      check("rst_is_character", int'(is_character), 0);
      check("rst_rom_addr", int'(rom_addr), 0);
      check("rst_anim_done", int'(anim_done), 0);
      Reset_n = 1'b1;
      repeat (4) @(posedge Clk);
      #1;

      write_desc(0, 42, 104, 4, 1);
      write_desc(1, 42, 80, 2, 0);
      write_desc(2, 42, 60, 3, 1);
      for (int i = 3; i < 6; i++)
         write_desc(i, 42, 2 * $urandom_range(10, 60), $urandom_range(0, 5), $urandom_range(0, 1));

      DrawX = 10'd60; DrawY = 10'd310; facing_left = 1'b0;
      @(posedge Clk); #1;
      check("first_px_addr", int'(rom_addr), 110);

      // Looping animation on state 0
      for (int t = 0; t < 20; t++) tick(0, 0, 0, 0, 0, 0);
      check("loop_frame_after_20", int'(anim_frame), 1);

      for (int t = 0; t < 10; t++) tick(0, 1, 0, 0, 0, 0);
      check("move_r_10", int'(character_x), 70);
      tick(0, 1, 1, 0, 0, 0);
      check("move_both", int'(character_x), 70);
      tick(0, 1, 0, 1, 0, 0);
      check("hurt_override", int'(character_x), 65);
      while (m_x > 14) tick(0, 0, 0, 1, 0, 0);
      for (int t = 0; t < 4; t++) tick(0, 0, 1, 0, 0, 0);
      check("clamp_xmin", int'(character_x), 10);
      tick(0, 0, 0, 1, 0, 0);
      check("hurt_at_xmin", int'(character_x), 10);

      // One-shot animation: holds last frame, single anim_done pulse
      done_cnt = 0; exp_done = 0;
      tick(1, 0, 0, 0, 0, 0);
      for (int t = 0; t < 14; t++) tick(1, 0, 0, 0, 0, 0);
      check("oneshot_hold_frame", int'(anim_frame), 1);
      check("oneshot_done_cycles", done_cnt, exp_done);
      check("oneshot_done_once", done_cnt, 1);

      // Opponent collision clamp
      write_desc(1, 50, 80, 2, 0);
      while (m_x < 48) tick(1, 1, 0, 0, 0, 0);
      check("coll_setup_x", int'(character_x), 48);
      tick(1, 1, 0, 0, 1, 100);
      check("coll_clamp", int'(character_x), 50);
      tick(1, 1, 0, 0, 0, 100);
      check("coll_released", int'(character_x), 52);
      write_desc(1, 42, 80, 2, 0);

      // Random movement and state changes
      for (int t = 0; t < 60; t++) begin
         st = ($urandom_range(0, 9) < 6) ? m_state : $urandom_range(0, 5);
         ox = m_x + m_w[m_state] + $urandom_range(0, 8) - 4;
         if (ox > 1023) ox = 1023;
         tick(st, $urandom_range(0, 1), $urandom_range(0, 1), ($urandom_range(0, 5) == 0) ? 1 : 0,
              $urandom_range(0, 1), ox);
      end
      check("random_done_cycles", done_cnt, exp_done);

      // Pixel pipeline bursts, with a mid-stream width rewrite of the active state
      for (int b = 0; b < 6; b++) begin
         tick($urandom_range(0, 5), $urandom_range(0, 1), 0, 0, 0, 0);
         nw = 2 * $urandom_range(15, 30);
         for (int p = 0; p < 40; p++)
            pixel(m_x - 4 + $urandom_range(0, m_w[m_state] + 8),
                  296 + $urandom_range(0, m_h[m_state] + 8),
                  $urandom_range(0, 1), (p == 20) ? nw : -1);
         pixel(m_x, 300, 1, -1);
         pixel(m_x + m_w[m_state], 300, 0, -1);
         pix_valid = 1'b0;
         repeat (3) @(posedge Clk);
         #1;
      end
      check("sb_drained", q_addr.size() + q_is.size(), 0);

      // Asynchronous reset mid-operation with the strobe held high across release
      move_r = 1'b1;
      frame_clk = 1'b1;
      @(posedge Clk); #3;
      Reset_n = 1'b0;
      #1;
      check("async_rst_x", int'(character_x), 50);
      check("async_rst_frame", int'(anim_frame), 0);
      check("async_rst_addr", int'(rom_addr), 0);
      repeat (3) @(posedge Clk);
      #1;
      Reset_n = 1'b1;
      model_reset();
      repeat (10) @(posedge Clk);
      #1;
      check("no_tick_after_rst", int'(character_x), 50);
      frame_clk = 1'b0;
      repeat (6) @(posedge Clk);
      #1;
      write_desc(0, 42, 104, 4, 1);
      for (int t = 0; t < 6; t++) tick(0, 1, 0, 0, 0, 0);
      check("post_rst_move", int'(character_x), 62);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/sprite_animator.md
# sprite_animator

Parametrised character sprite engine for the fighting-game video path. It holds per-state sprite geometry in a writable descriptor table and updates the character position and animation frame once per video frame. For each pixel it produces a pipelined sprite-ROM address plus a latency-aligned hit flag with transparency keying and horizontal flip. It sits between the game-logic FSM, the per-state sprite ROMs (1-cycle synchronous read) and the colour mapper.

## Interface
Parameters:
- NUM_STATES, 6: animation states; state index width SW = clog2(NUM_STATES)
- COORD_W, 10: pixel coordinate width
- ADDR_W, 19: sprite-ROM address width
- SCALE_SHIFT, 1: display scale = 2^SCALE_SHIFT (source pixel = display >> SCALE_SHIFT)
- FRAME_HOLD, 4: frame ticks per animation frame
- STEP, 2 / KNOCKBACK, 5: move and hurt displacement per tick, in pixels
- X_MIN, 10 / X_MAX, 630 / X_INIT, 50 / Y_INIT, 300: horizontal limits and reset position
- TRANSPARENT, 8'h00: palette index treated as background

Ports:
- Clk, in, 1: system clock (50 MHz)
- Reset_n, in, 1: asynchronous, active-low reset
- frame_clk, in, 1: ~60 Hz frame strobe, asynchronous to Clk
- state_in, in, SW: requested animation state from game FSM
- facing_left, in, 1: mirror sprite horizontally
- move_r, move_l, hurt, in, 1: movement requests
- opp_x, in, COORD_W: opponent left edge; opp_block, in, 1: enables opponent collision clamp
- desc_we, in, 1; desc_idx, in, SW; desc_data, in, 2*COORD_W+9: descriptor write = {width, height, frames[7:0], loop}
- DrawX, DrawY, in, COORD_W: current pixel
- rom_sel, out, SW: ROM select; rom_addr, out, ADDR_W: ROM address
- rom_data, in, 8: palette index returned one cycle after rom_addr
- is_character, out, 1: opaque sprite pixel, aligned with rom_data
- data_Out, out, 8: palette index, aligned with is_character
- character_x, out, COORD_W; anim_frame, out, 8; anim_done, out, 1

## Operation
- Frame tick: frame_clk passes through a 2-flop synchroniser. A rising-edge detect produces a 1-cycle `tick`. Position, state and animation update only on `tick`.
- Descriptor table: NUM_STATES registers, zeroed on reset. A write takes effect the cycle after desc_we. Width 0 makes the sprite invisible. frames = 0 is treated as 1.
- State/animation on tick:
  - If state_in differs from the current state: load state_in, anim_frame := 0, hold := 0, anim_done := 0.
  - Otherwise hold increments. When hold = FRAME_HOLD-1, hold := 0 and the frame advances.
  - At the last frame, loop=1 wraps to 0. loop=0 holds the last frame and pulses anim_done for 1 Clk cycle, once per entry to that state.
- Position on tick, evaluated in this order:
  - hurt: x − KNOCKBACK (overrides move).
  - Else move_r only: +STEP. move_l only: −STEP. Both or neither: no change.
  - If opp_block and nx + w ≥ opp_x: nx := opp_x − w.
  - Clamp nx to [X_MIN, X_MAX − w].
  - Arithmetic is done in COORD_W+2 signed bits, so underflow clamps to X_MIN and does not wrap.
  - Y is fixed at Y_INIT.
- Pixel stage 1 (registered):
  - dx = DrawX − x, dy = DrawY − Y_INIT.
  - hit = 0 ≤ dx < w and 0 ≤ dy < h.
  - sx = dx >> SCALE_SHIFT; if facing_left, sx := sw − 1 − sx, where sw = w >> SCALE_SHIFT and sh = h >> SCALE_SHIFT.
  - rom_addr = frame·sw·sh + (dy >> SCALE_SHIFT)·sw + sx, truncated to ADDR_W.
  - rom_sel = current state. On a miss, rom_addr := 0.
- Pixel stage 2: is_character = hit_d & (rom_data ≠ TRANSPARENT); data_Out = rom_data when is_character, else 0.

## Timing
- Reset values: character_x = X_INIT, state 0, anim_frame 0, hold 0, anim_done 0, rom_sel 0, rom_addr 0, is_character 0, data_Out 0, descriptors 0, synchroniser 0.
- Reset assertion mid-operation clears everything asynchronously. The first tick after release needs a fresh frame_clk rising edge.
- tick occurs 3 Clk cycles after the frame_clk rising edge. State, position and frame update on the cycle after tick.
- Pixel latency: DrawX/DrawY at cycle N → rom_addr/rom_sel at N+1 → is_character/data_Out at N+2. One pixel per cycle, no stalls.
- Geometry used by stage 1 is the descriptor registered at the start of the cycle. A descriptor write to the active state applies from the next pixel.
- A state change and a tick in the same cycle: the change has priority, and no frame advance happens on that tick.

## Test plan
- Reset: hold Reset_n low, toggle Clk → character_x = 50, is_character = 0, anim_frame = 0. Release, drive DrawX = 60, DrawY = 310 with descriptor 0 = {42, 104, 4, 1} → rom_addr = 5·21 + 5 = 110 at N+1, and rom_data = 8'h00 gives is_character = 0.
- Animation: state 0 loop, frames = 4, FRAME_HOLD = 4, 20 ticks → anim_frame sequence 0,0,0,0,1,…,3,0, wraps at tick 16. Non-loop state with frames = 2 → holds at frame 1, anim_done high exactly 1 cycle.
- Movement: move_r for 10 ticks → x = 70. move_r and move_l together → no change. hurt with move_r → x −= 5. From x = 12, move_l → x = 10 (clamp, no wrap).
- Collision: opp_block = 1, opp_x = 100, w = 50, x = 48, move_r → x = 50. opp_block = 0 → x = 52.
- Flip and pipeline: facing_left = 1, w = 42, dx = 0 → sx = 20. Back-to-back DrawX values → addresses appear one per cycle, aligned 1 cycle later. Transparent index is masked.
- Descriptor update mid-frame: write a new width to the active state → the hit window changes from the next pixel. frame_clk toggling faster than Clk edge-detect resolution is not required.
